dnn_result_collector: RTL and testbench

- Downstream neighbour of the DNN inference datapath. Consumes the signed out0/out1 results and their out0_ready/out1_ready flags.
- Captures each new inference result exactly once and classifies it by argmax. Computes the score margin.
- Buffers results in a small FIFO that drains over a valid/ready stream interface to the host/readout logic.

---
 rtl/dnn_pkg.sv | 23 ++
 rtl/dnn_res_fifo.sv | 56 +++++
 rtl/dnn_result_collector.sv | 99 +++++++++
 tb/tb_dnn_result_collector.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types and helpers for the DNN result collector: result width rule,
// the per-entry record layout and the statistics counter width.
package dnn_pkg;

    localparam int RES_CNT_W = 16;
    localparam int DEF_I_W   = 7;

    function automatic int ow(input int i_w);
        return i_w + 13;
    endfunction

    localparam int DEF_OW = ow(DEF_I_W);

    // Record layout at the default datapath width; the collector builds the
    // same layout at its own I_W and hands it to the FIFO as a type parameter.
    typedef struct packed {
        logic              cls;
        logic [DEF_OW-1:0] score0;
        logic [DEF_OW-1:0] score1;
        logic [DEF_OW:0]   margin;
    } dnn_res_t;

endpackage

// File: rtl/dnn_res_fifo.sv
// Synchronous FIFO of result records with occupancy count; a push into a full
// FIFO is accepted only when a pop frees the head slot in the same cycle.
module dnn_res_fifo
    import dnn_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = dnn_res_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    // Empty FIFO presents an all-zero record rather than stale memory.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dnn_result_collector.sv
// Captures each new DNN result once (rising edge of both readies), classifies it
// by argmax, buffers it and streams it out. Optional stats: DNN_RES_STATS_EN.
module dnn_result_collector
    import dnn_pkg::*;
#(
    parameter int  I_W   = 7,
    parameter int  DEPTH = 4,
    localparam int OW    = ow(I_W),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [OW-1:0] out0,
    input  logic signed [OW-1:0] out1,
    input  logic                 out0_ready,
    input  logic                 out1_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_class,
    output logic [OW-1:0]        m_score0,
    output logic [OW-1:0]        m_score1,
    output logic [OW:0]          m_margin,
    output logic [CW-1:0]        count,
    output logic                 ovf,
    output logic [RES_CNT_W-1:0] res_cnt
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dnn_result_collector: DEPTH must be a power of two in 2..16");
    end

    typedef struct packed {
        logic          cls;
        logic [OW-1:0] score0;
        logic [OW-1:0] score1;
        logic [OW:0]   margin;
    } res_t;

    logic        both, both_q, push, pop, full, empty, accept;
    logic [OW:0] diff;
    res_t        wr_res, head;

    assign both = out0_ready & out1_ready;
    assign push = both & ~both_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) both_q <= 1'b0;
        else        both_q <= both;
    end

    // Sign-extend by one bit so the difference can never overflow.
    assign diff = {out0[OW-1], out0} - {out1[OW-1], out1};

    always_comb begin
        wr_res        = '0;
        wr_res.cls    = (out1 > out0);
        wr_res.score0 = out0;
        wr_res.score1 = out1;
        wr_res.margin = diff[OW] ? (~diff + 1'b1) : diff;
    end

    assign pop    = m_valid & m_ready;
    assign accept = push & (~full | pop);

    dnn_res_fifo #(.DEPTH(DEPTH), .T(res_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (wr_res),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign m_valid  = ~empty;
    assign m_class  = head.cls;
    assign m_score0 = head.score0;
    assign m_score1 = head.score1;
    assign m_margin = head.margin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   ovf <= 1'b0;
        else if (push & full & ~pop)  ovf <= 1'b1;
    end

`ifdef DNN_RES_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    res_cnt <= '0;
        else if (accept & wr_res.cls)  res_cnt <= res_cnt + 1'b1;
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign res_cnt       = '0;
`endif

endmodule

// File: tb/tb_dnn_result_collector.sv
// Scoreboard bench for dnn_result_collector (DEPTH=4, I_W=7 -> 20-bit scores).
module tb_dnn_result_collector;
    import dnn_pkg::*;

    localparam int OW = 20;

    logic                 clk;
    logic                 rst_n;
    logic signed [OW-1:0] out0, out1;
    logic                 out0_ready, out1_ready;
    logic                 m_valid, m_ready, m_class;
    logic [OW-1:0]        m_score0, m_score1;
    logic [OW:0]          m_margin;
    logic [2:0]           count;
    logic                 ovf;
    logic [15:0]          res_cnt;

    typedef struct {
        logic          cls;
        logic [OW-1:0] s0;
        logic [OW-1:0] s1;
        logic [OW:0]   mg;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   exp_res = 0;

    dnn_result_collector #(.I_W(7), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .out0(out0), .out1(out1),
        .out0_ready(out0_ready), .out1_ready(out1_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .m_score0(m_score0), .m_score1(m_score1), .m_margin(m_margin),
        .count(count), .ovf(ovf), .res_cnt(res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout watchdog expired");
        $fatal(1);
    end

    // Popped entries are compared against the queue head on the falling edge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got class=%0d s0=%0d s1=%0d exp no entry",
                         m_class, $signed(m_score0), $signed(m_score1));
            end else begin
                e = q.pop_front();
                if ({m_class, m_score0, m_score1, m_margin} !== {e.cls, e.s0, e.s1, e.mg}) begin
                    errors++;
                    $display("FAIL pop_entry got c=%0d s0=%0d s1=%0d mg=%0d exp c=%0d s0=%0d s1=%0d mg=%0d",
                             m_class, $signed(m_score0), $signed(m_score1), m_margin,
                             e.cls, $signed(e.s0), $signed(e.s1), e.mg);
                end
            end
        end
    end

    function automatic int exp_cnt();
`ifdef DNN_RES_STATS_EN
        return exp_res & 16'hFFFF;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input int a, input int b);
        exp_t x;
        int   d;
        d      = (a > b) ? (a - b) : (b - a);
        x.cls  = (b > a);
        x.s0   = a[OW-1:0];
        x.s1   = b[OW-1:0];
        x.mg   = d[OW:0];
        q.push_back(x);
        if (x.cls) exp_res++;
    endtask

    task automatic send(input int a, input int b, input bit accepted);
        out0 = a[OW-1:0];
        out1 = b[OW-1:0];
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        if (accepted) expect_push(a, b);
        tick();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        tick();
    endtask

    task automatic drain(input int n, input string tag);
        m_ready = 1'b1;
        repeat (n) tick();
        m_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got count=%0d left=%0d exp 0 0", tag, count, q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        m_ready = 1'b0;
        out0 = '0;
        out1 = '0;
        q.delete();
        exp_res = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out0 = 20'sd33;
        out1 = 20'sd44;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        m_ready = 1'b1;
        tick();
        checks++;
        if ({m_valid, count, ovf, res_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state got v=%0d cnt=%0d ovf=%0d rc=%0d exp 0", m_valid, count, ovf, res_cnt);
        end
        checks++;
        if ({m_class, m_score0, m_score1, m_margin} !== '0) begin
            errors++;
            $display("FAIL reset_head got c=%0d s0=%0d s1=%0d mg=%0d exp 0", m_class, m_score0, m_score1, m_margin);
        end
        m_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got m_valid=%0d exp 0", m_valid);
        end
    endtask

    task automatic test_single();
        out0 = 20'sd100;
        out1 = -20'sd50;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        expect_push(100, -50);
        tick();
        checks++;
        if (m_valid !== 1'b1 || count !== 3'd1 || m_class !== 1'b0 || m_margin !== 21'd150) begin
            errors++;
            $display("FAIL single_capture got v=%0d cnt=%0d c=%0d mg=%0d exp 1 1 0 150",
                     m_valid, count, m_class, m_margin);
        end
        repeat (4) tick();
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL single_held got count=%0d exp 1", count);
        end
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drain(1, "single");
    endtask

    task automatic test_tie_neg();
        send(-20, -20, 1'b1);
        send(-300, -299, 1'b1);
        checks++;
        if (count !== 3'd2 || m_class !== 1'b0 || m_margin !== 21'd0) begin
            errors++;
            $display("FAIL tie_head got cnt=%0d c=%0d mg=%0d exp 2 0 0", count, m_class, m_margin);
        end
        drain(2, "tie_neg");
    endtask

    task automatic test_skew();
        out0 = 20'sd7;
        out1 = 20'sd9;
        out0_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL skew_early got count=%0d exp 0", count);
        end
        out1_ready = 1'b1;
        expect_push(7, 9);
        tick();
        checks++;
        if (count !== 3'd1 || m_class !== 1'b1) begin
            errors++;
            $display("FAIL skew_push got cnt=%0d c=%0d exp 1 1", count, m_class);
        end
        repeat (3) tick();
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL skew_once got count=%0d exp 1", count);
        end
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drain(1, "skew");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++)
            send(i * 10 - 15, (i % 2 == 0) ? i * 10 - 10 : i * 10 - 20, i < 4);
        checks++;
        if (count !== 3'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full got cnt=%0d ovf=%0d exp 4 1", count, ovf);
        end
        checks++;
        if (res_cnt !== 16'(exp_cnt())) begin
            errors++;
            $display("FAIL ovf_rescnt got %0d exp %0d", res_cnt, exp_cnt());
        end
        drain(4, "ovf");
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %0d exp 1", ovf);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 4; i++) send(i + 1, -i, 1'b1);
        out0 = 20'sd55;
        out1 = -20'sd5;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        m_ready = 1'b1;
        expect_push(55, -5);
        tick();
        m_ready = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        checks++;
        if (count !== 3'd4 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop got cnt=%0d ovf=%0d exp 4 0", count, ovf);
        end
        drain(4, "full_pushpop");
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(1, 2, 1'b1);
        send(3, 1, 1'b1);
        out0 = -20'sd4;
        out1 = 20'sd8;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        expect_push(-4, 8);
        tick();
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL rmid_pre got count=%0d exp 3", count);
        end
        rst_n = 1'b0;
        q.delete();
        exp_res = 0;
        #1;
        checks++;
        if (count !== 3'd0 || ovf !== 1'b0 || m_valid !== 1'b0 || res_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rmid_reset got cnt=%0d ovf=%0d v=%0d rc=%0d exp 0 0 0 0", count, ovf, m_valid, res_cnt);
        end
        tick();
        rst_n = 1'b1;
        expect_push(-4, 8);
        tick();
        checks++;
        if (count !== 3'd1 || m_class !== 1'b1 || m_margin !== 21'd12) begin
            errors++;
            $display("FAIL rmid_push got cnt=%0d c=%0d mg=%0d exp 1 1 12", count, m_class, m_margin);
        end
        checks++;
        if (res_cnt !== 16'(exp_cnt())) begin
            errors++;
            $display("FAIL rmid_rescnt got %0d exp %0d", res_cnt, exp_cnt());
        end
        repeat (2) tick();
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL rmid_once got count=%0d exp 1", count);
        end
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drain(1, "rmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie_neg();
        test_skew();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
